// File: rtl/nano_fetch_if.sv
// Fetch-stage handshake bundle: instruction-memory request/response, redirect
// from execute, and the instruction hand-off to the core.
interface nano_fetch_if;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;

  // master: the fetch stage itself; slave: memory + core side.
  modport master (
    output o_imem_req_valid, o_imem_addr, o_inst_valid, o_inst, o_inst_pc,
    input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
    input  i_redirect, i_redirect_pc, i_inst_ready
  );

  modport slave (
    input  o_imem_req_valid, o_imem_addr, o_inst_valid, o_inst, o_inst_pc,
    output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
    output i_redirect, i_redirect_pc, i_inst_ready
  );
endinterface

// File: rtl/nano_fetch.sv
// Instruction fetch stage: credit-limited in-order fetch into a small buffer,
// registered instruction/PC output, redirect with flush of in-flight responses.
module nano_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic          i_clk,
  input logic          i_rst,
  nano_fetch_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e        state_q;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic          req_valid_q, req_valid_d;
  logic          inst_valid_q, inst_valid_d;
  logic [31:0]   inst_q, inst_d, inst_pc_q, inst_pc_d;
  logic [31:0]   mem_data_q [FIFO_DEPTH];
  logic [31:0]   mem_pc_q   [FIFO_DEPTH];
  logic          accept, rsp, push, pop, run_next;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    accept     = req_valid_q & bus.i_imem_req_ready;
    rsp        = bus.i_imem_rsp_valid;
    push       = rsp & (state_q == RUN) & ~bus.i_redirect;
    pop        = inst_valid_q & bus.i_inst_ready & ~bus.i_redirect;
    inflight_d = inflight_q + CW'(accept) - CW'(rsp);

    if (bus.i_redirect) begin
      // Everything still in flight, including this cycle's request, is stale.
      drop_d   = inflight_d;
      addr_d   = {bus.i_redirect_pc[31:2], 2'b00};
      rsp_pc_d = {bus.i_redirect_pc[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      drop_d   = (state_q == FLUSH && rsp) ? drop_q - CW'(1) : drop_q;
      addr_d   = accept ? addr_q + 32'd4 : addr_q;
      rsp_pc_d = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
    end

    run_next    = (drop_d == '0);
    req_valid_d = run_next &&
                  (({1'b0, inflight_d} + {1'b0, count_d}) < (CW+1)'(FIFO_DEPTH));

    inst_valid_d = (count_d != '0);
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    if (count_d != '0) begin
      // Buffer drains to empty and refills this cycle: head is the incoming word.
      if (push && (count_q == CW'(pop))) begin
        inst_d    = bus.i_imem_rsp_data;
        inst_pc_d = rsp_pc_q;
      end else begin
        inst_d    = mem_data_q[rd_ptr_d];
        inst_pc_d = mem_pc_q[rd_ptr_d];
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= RUN;
      drop_q       <= '0;
      inflight_q   <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      addr_q       <= RESET_PC;
      rsp_pc_q     <= RESET_PC;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= run_next ? RUN : FLUSH;
      drop_q       <= drop_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      addr_q       <= addr_d;
      rsp_pc_q     <= rsp_pc_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  // NOTE: the storage array is not reset; count and pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= bus.i_imem_rsp_data;
      mem_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

  assign bus.o_imem_req_valid = req_valid_q;
  assign bus.o_imem_addr      = addr_q;
  assign bus.o_inst_valid     = inst_valid_q;
  assign bus.o_inst           = inst_q;
  assign bus.o_inst_pc        = inst_pc_q;

  rsp_needs_inflight: assert property (@(posedge i_clk) disable iff (i_rst)
    bus.i_imem_rsp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_nano_fetch.sv
// Self-checking bench for nano_fetch: cycle table, directed corner sequences,
// and randomized traffic against a program-order reference model.
module tb_nano_fetch;
  localparam int DEPTH = 2;

  logic clk  = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  nano_fetch_if bus0();
  nano_fetch_if bus1();

  nano_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut0 (
    .i_clk(clk), .i_rst(rst0), .bus(bus0));
  nano_fetch #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut1 (
    .i_clk(clk), .i_rst(rst1), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outstanding memory requests tagged with the redirect epoch
  // they were issued in, instructions buffered, next expected PCs.
  typedef struct { logic [31:0] addr; int epoch; } req_t;
  req_t        pend_q[$];
  int          epoch    = 0;
  int          buffered = 0;
  int          pops     = 0;
  logic [31:0] exp_pc, exp_req_addr;

  typedef struct {
    logic rdy; logic irdy;
    logic exp_v; logic [31:0] exp_addr; logic exp_iv; logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl [9];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_state();
    int stale = 0;
    foreach (pend_q[i]) if (pend_q[i].epoch != epoch) stale++;
    check("req_valid", bus0.o_imem_req_valid,
          (stale == 0) && ((pend_q.size() + buffered) < DEPTH));
    check("req_addr_reg", bus0.o_imem_addr, exp_req_addr);
    check("inst_valid", bus0.o_inst_valid, buffered > 0);
    if (buffered > 0) begin
      check("inst_pc", bus0.o_inst_pc, exp_pc);
      check("inst_data", bus0.o_inst, mem_word(exp_pc));
    end
  endtask

  // One clock of dut0: drive inputs, advance the model by the events of this edge.
  task automatic cycle(input logic rdy, input logic irdy, input logic redir,
                       input logic [31:0] tgt, input logic allow_rsp);
    logic acc, rsp, pop;
    req_t e;
    acc = bus0.o_imem_req_valid & rdy;
    rsp = allow_rsp && (pend_q.size() != 0);
    pop = bus0.o_inst_valid & irdy & ~redir;
    bus0.i_imem_req_ready = rdy;
    bus0.i_inst_ready     = irdy;
    bus0.i_redirect       = redir;
    bus0.i_redirect_pc    = tgt;
    bus0.i_imem_rsp_valid = rsp;
    bus0.i_imem_rsp_data  = rsp ? mem_word(pend_q[0].addr) : $urandom;
    if (acc) begin
      check("req_addr", bus0.o_imem_addr, exp_req_addr);
      pend_q.push_back('{addr: exp_req_addr, epoch: epoch});
      exp_req_addr += 32'd4;
    end
    if (rsp) begin
      e = pend_q.pop_front();
      if (e.epoch == epoch && !redir) buffered++;
    end
    if (pop && buffered > 0) begin
      buffered--;
      exp_pc += 32'd4;
      pops++;
    end
    if (redir) begin
      epoch++;
      buffered     = 0;
      exp_pc       = {tgt[31:2], 2'b00};
      exp_req_addr = {tgt[31:2], 2'b00};
    end
    tick();
    check_state();
  endtask

  task automatic do_reset();
    bus0.i_imem_req_ready = 1'b0;
    bus0.i_inst_ready     = 1'b0;
    bus0.i_redirect       = 1'b0;
    bus0.i_redirect_pc    = '0;
    bus0.i_imem_rsp_valid = 1'b0;
    bus0.i_imem_rsp_data  = '0;
    rst0 = 1'b1;
    tick();
    check("rst_req_valid", bus0.o_imem_req_valid, 1'b0);
    check("rst_addr", bus0.o_imem_addr, 32'h0);
    check("rst_inst_valid", bus0.o_inst_valid, 1'b0);
    check("rst_inst", bus0.o_inst, 32'h0);
    check("rst_inst_pc", bus0.o_inst_pc, 32'h0);
    tick();
    rst0 = 1'b0;
    pend_q.delete();
    epoch++;
    buffered     = 0;
    exp_pc       = 32'h0;
    exp_req_addr = 32'h0;
  endtask

  initial begin
    bus1.i_imem_req_ready = 1'b0;
    bus1.i_inst_ready     = 1'b0;
    bus1.i_redirect       = 1'b0;
    bus1.i_redirect_pc    = '0;
    bus1.i_imem_rsp_valid = 1'b0;
    bus1.i_imem_rsp_data  = '0;

    // Everything ready, one-cycle memory: credit of 2 gives a 3-cycle pattern.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h10};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].rdy, tbl[i].irdy, 1'b0, 32'h0, 1'b1);
      check("t1_req_valid", bus0.o_imem_req_valid, tbl[i].exp_v);
      check("t1_addr", bus0.o_imem_addr, tbl[i].exp_addr);
      check("t1_inst_valid", bus0.o_inst_valid, tbl[i].exp_iv);
      if (tbl[i].exp_iv) check("t1_inst_pc", bus0.o_inst_pc, tbl[i].exp_pc);
    end

    // Core stalled: buffer fills with 0x0,0x4 and requests stop.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("t2_req_stopped", bus0.o_imem_req_valid, 1'b0);
    check("t2_head_pc", bus0.o_inst_pc, 32'h0);
    check("t2_inst_valid", bus0.o_inst_valid, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t2_second_pc", bus0.o_inst_pc, 32'h4);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t2_third_pc", bus0.o_inst_pc, 32'h8);

    // Reset while the buffer is full.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t6_restart_addr", bus0.o_imem_addr, 32'h4);

    // Two requests in flight, then redirect to 0x100.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("t3_two_inflight", bus0.o_imem_req_valid, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    check("t3_redir_addr", bus0.o_imem_addr, 32'h100);
    check("t3_no_req", bus0.o_imem_req_valid, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t3_still_flushing", bus0.o_imem_req_valid, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t3_resume", bus0.o_imem_req_valid, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t3_new_pc", bus0.o_inst_pc, 32'h100);
    check("t3_new_data", bus0.o_inst, mem_word(32'h100));

    // Redirect to 0x103 colliding with a response and a pop.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t4_pre_valid", bus0.o_inst_valid, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h103, 1'b1);
    check("t4_addr", bus0.o_imem_addr, 32'h100);
    check("t4_flushed", bus0.o_inst_valid, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t4_new_pc", bus0.o_inst_pc, 32'h100);

    // Randomized traffic with a mid-stream reset.
    do_reset();
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cycle(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 25) == 0,
            $urandom & 32'h0000_FFFF, ($urandom % 3) != 0);
    end
    check("rand_progress", pops >= 300, 1'b1);

    // Fetch PC wrap from 0xFFFF_FFFC.
    tick();
    check("t5_rst_addr", bus1.o_imem_addr, 32'hFFFF_FFFC);
    rst1 = 1'b0;
    bus1.i_imem_req_ready = 1'b1;
    bus1.i_inst_ready     = 1'b1;
    tick();
    check("t5_req_valid", bus1.o_imem_req_valid, 1'b1);
    check("t5_addr0", bus1.o_imem_addr, 32'hFFFF_FFFC);
    tick();
    check("t5_addr1", bus1.o_imem_addr, 32'h0000_0000);
    bus1.i_imem_rsp_valid = 1'b1;
    bus1.i_imem_rsp_data  = mem_word(32'hFFFF_FFFC);
    tick();
    check("t5_pc0", bus1.o_inst_pc, 32'hFFFF_FFFC);
    check("t5_data0", bus1.o_inst, mem_word(32'hFFFF_FFFC));
    check("t5_addr2", bus1.o_imem_addr, 32'h0000_0004);
    bus1.i_imem_rsp_data = mem_word(32'h0);
    tick();
    bus1.i_imem_rsp_valid = 1'b0;
    check("t5_pc1", bus1.o_inst_pc, 32'h0000_0000);
    check("t5_data1", bus1.o_inst, mem_word(32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
